// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT peak detector: frame geometry,
// the packed complex sample and the control FSM state.
package fft_pkg;
  localparam int N_POINTS = 512;
  localparam int ADDR_W   = 9;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } state_t;
endpackage

// File: rtl/fft_peak_detect_mag_sq.sv
// Two-stage re^2 + im^2 pipeline: stage 1 registers both squares, stage 2 the
// 32-bit unsigned sum. The bin index travels with the data.
module mag_sq
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_bin,
  input  cplx_t             in_data,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_bin,
  output logic [31:0]       out_mag
);
  logic              s1_valid;
  logic [ADDR_W-1:0] s1_bin;
  logic [30:0]       re_sq;
  logic [30:0]       im_sq;
  logic [30:0]       re_sq_c;
  logic [30:0]       im_sq_c;

  // A signed square is never negative and at most 2^30, so 31 bits hold it exactly.
  always_comb begin
    re_sq_c = 31'(in_data.re * in_data.re);
    im_sq_c = 31'(in_data.im * in_data.im);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_bin    <= '0;
      re_sq     <= '0;
      im_sq     <= '0;
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_mag   <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_bin   <= in_bin;
      re_sq    <= re_sq_c;
      im_sq    <= im_sq_c;
      // A flush drops the word already in flight so it cannot reach a new frame.
      out_valid <= s1_valid && !flush;
      out_bin   <= s1_bin;
      out_mag   <= {1'b0, re_sq} + {1'b0, im_sq};
    end
  end
endmodule

// File: rtl/fft_peak_detect.sv
// Scans one FFT output frame for the largest-magnitude bin inside a search
// window and reports its index and re^2+im^2 once per completed frame.
module fft_peak_detect #(
  parameter int          N_POINTS   = fft_pkg::N_POINTS,
  parameter int          BIN_LO     = 1,
  parameter int          BIN_HI     = 255,
  parameter logic [31:0] MAG_THRESH = 32'd0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_start,
  input  logic                       in_valid,
  input  logic [31:0]                in_data,
  output logic                       busy,
  output logic                       peak_valid,
  output logic                       peak_found,
  output logic [fft_pkg::ADDR_W-1:0] peak_bin,
  output logic [31:0]                peak_mag,
  output fft_pkg::state_t            state
);
  import fft_pkg::*;

  // Handshake: a word is taken on any posedge where in_valid=1 and either
  // frame_start=1 or the FSM is in ACCUM; there is no back-pressure.
  state_t            state_q;
  state_t            next_state;
  logic [ADDR_W-1:0] cnt_q;
  logic              drain_q;
  logic              accept;
  logic              last_word;
  logic [ADDR_W-1:0] acc_bin;
  logic              report_load;

  logic              s2_valid;
  logic [ADDR_W-1:0] s2_bin;
  logic [31:0]       s2_mag;
  logic              in_range;
  logic              qualify;

  logic              max_found;
  logic [ADDR_W-1:0] max_bin;
  logic [31:0]       max_mag;
  logic              cand_found;
  logic [ADDR_W-1:0] cand_bin;
  logic [31:0]       cand_mag;

  always_comb begin
    accept    = in_valid && (frame_start || (state_q == ACCUM));
    acc_bin   = frame_start ? '0 : cnt_q;
    last_word = accept && !frame_start && (cnt_q == ADDR_W'(N_POINTS - 1));
  end

  always_comb begin
    next_state = state_q;
    case (state_q)
      IDLE:    next_state = IDLE;
      ACCUM:   if (last_word) next_state = DRAIN;
      DRAIN:   if (drain_q) next_state = REPORT;
      REPORT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (frame_start) next_state = ACCUM;
  end

  mag_sq u_mag_sq (
    .clk       (clk),
    .reset     (reset),
    .flush     (frame_start),
    .in_valid  (accept),
    .in_bin    (acc_bin),
    .in_data   (cplx_t'(in_data)),
    .out_valid (s2_valid),
    .out_bin   (s2_bin),
    .out_mag   (s2_mag)
  );

  // Strict compare keeps the earlier (lower) bin on equal magnitudes.
  always_comb begin
    in_range   = (int'(s2_bin) >= BIN_LO) && (int'(s2_bin) <= BIN_HI);
    qualify    = s2_valid && in_range && (s2_mag > max_mag) && (s2_mag > MAG_THRESH);
    cand_found = qualify ? 1'b1   : max_found;
    cand_bin   = qualify ? s2_bin : max_bin;
    cand_mag   = qualify ? s2_mag : max_mag;
  end

  // The last word's magnitude leaves the pipeline on the edge entering REPORT,
  // so the report is taken from the candidate rather than the stored max.
  assign report_load = (state_q == DRAIN) && (next_state == REPORT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      drain_q    <= 1'b0;
      max_found  <= 1'b0;
      max_bin    <= '0;
      max_mag    <= '0;
      peak_valid <= 1'b0;
      peak_found <= 1'b0;
      peak_bin   <= '0;
      peak_mag   <= '0;
    end else begin
      state_q <= next_state;
      drain_q <= (state_q == DRAIN);
      if (frame_start) cnt_q <= in_valid ? ADDR_W'(1) : '0;
      else if (accept) cnt_q <= cnt_q + 1'b1;
      if (frame_start) begin
        max_found <= 1'b0;
        max_bin   <= '0;
        max_mag   <= '0;
      end else if (qualify) begin
        max_found <= 1'b1;
        max_bin   <= s2_bin;
        max_mag   <= s2_mag;
      end
      peak_valid <= report_load;
      if (report_load) begin
        peak_found <= cand_found;
        peak_bin   <= cand_bin;
        peak_mag   <= cand_mag;
      end
    end
  end

  assign busy  = (state_q == ACCUM) || (state_q == DRAIN);
  assign state = state_q;
endmodule

// File: doc/fft_peak_detect.md
FFT_PEAK_DETECT -- requirements
Module: fft_peak_detect

Interface
REQ-001 SHALL have parameter N_POINTS, default 512, meaning FFT frame length in words.
REQ-002 SHALL have parameter BIN_LO, default 1, meaning the lowest bin searched (1 excludes DC).
REQ-003 SHALL have parameter BIN_HI, default 255, meaning the highest bin searched (positive frequencies only).
REQ-004 SHALL have parameter MAG_THRESH, default 32'd0, meaning the minimum magnitude-squared a peak must strictly exceed.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port frame_start, input, 1, a pulse marking the start of a new FFT output frame.
REQ-008 SHALL have port in_valid, input, 1, meaning in_data carries one FFT output word this cycle.
REQ-009 SHALL have port in_data, input, 32, {re[31:16], im[15:0]}, each signed two's complement, same packing as the FFT data_out.
REQ-010 SHALL have port busy, output, 1, high while a frame is being accumulated or drained.
REQ-011 SHALL have port peak_valid, output, 1, a one-cycle pulse when the frame result is updated.
REQ-012 SHALL have port peak_found, output, 1, set if any searched bin exceeded MAG_THRESH.
REQ-013 SHALL have port peak_bin, output, 9, bin index of the maximum.
REQ-014 SHALL have port peak_mag, output, 32, unsigned re^2+im^2 of the maximum.

Function
REQ-015 SHALL implement FSM IDLE -> ACCUM (on frame_start) -> DRAIN (after word N_POINTS-1 is accepted) -> REPORT (after 2 drain cycles) -> IDLE (next cycle).
REQ-016 SHALL accept words only in ACCUM with in_valid=1, or in the same cycle as frame_start; in_valid in IDLE/DRAIN/REPORT is ignored.
REQ-017 SHALL, on frame_start in any state, clear the bin counter, running max and found flag and enter ACCUM; a word valid in that same cycle is bin 0.
REQ-018 SHALL keep a 9-bit bin counter incremented per accepted word; the word accepted at count N_POINTS-1 ends the frame (no wrap into the next frame).
REQ-019 SHALL compute mag = re*re + im*im from 16x16 signed products (31-bit each), summed as 32-bit unsigned with no overflow (max 2^31).
REQ-020 SHALL pipeline magnitude in 2 registered stages (products, then sum+compare), carrying the bin index alongside.
REQ-021 SHALL update the running max only when BIN_LO <= bin <= BIN_HI and mag > current max and mag > MAG_THRESH (strict; ties keep the lower bin).
REQ-022 SHALL assert peak_valid for exactly one cycle in REPORT, 3 cycles after the edge accepting word N_POINTS-1.
REQ-023 SHALL load peak_bin/peak_mag/peak_found only in REPORT and hold them until the next REPORT; if nothing qualified, peak_found=0, peak_bin=0, peak_mag=0.
REQ-024 SHALL drive busy=1 in ACCUM and DRAIN, 0 in IDLE and REPORT.
REQ-025 SHALL discard a partially accumulated frame without pulsing peak_valid when frame_start arrives mid-ACCUM or mid-DRAIN.
REQ-026 SHALL tolerate in_valid gaps of any length in ACCUM with no timeout.

Reset
REQ-027 SHALL, on reset low, asynchronously enter IDLE and clear the counter, pipeline, running max, busy, peak_valid, peak_found, peak_bin and peak_mag to 0.
REQ-028 SHALL, after reset release, ignore all input until the first frame_start.

Structure
REQ-029 SHALL take N_POINTS, ADDR_W=9, the packed complex-sample typedef {re, im} and the FSM state enum from the shared package fft_pkg.
REQ-030 SHALL place the 2-stage re^2+im^2 pipeline in sub-module mag_sq, instantiated once.

Verification
REQ-031 Bench SHALL drive frame_start then 512 words all 0 except bin 37 = {16'sd1000, 16'sd0} -> peak_valid 3 cycles after the last word, peak_bin=37, peak_mag=1000000, peak_found=1.
REQ-032 Bench SHALL drive bin 0 = {16'h7FFF, 16'h7FFF} and bin 300 = {16'sd2000, 0}, all else 0 -> peak_found=0, peak_bin=0 (DC and bin>255 excluded).
REQ-033 Bench SHALL drive bins 10 and 20 both = {-16'sd500, 16'sd500} -> peak_bin=10, peak_mag=500000 (tie keeps the lower bin).
REQ-034 Bench SHALL drive {16'h8000, 16'h8000} at bin 5 -> peak_mag=32'h8000_0000, with no overflow.
REQ-035 Bench SHALL issue frame_start at word 200, then a full frame with peak at bin 99 -> exactly one peak_valid, peak_bin=99.
REQ-036 Bench SHALL pull reset low during ACCUM (after bin 50) -> all outputs 0 immediately and no peak_valid until a new frame_start and 512 words.
